// File: rtl/rendering_mul_pipe.sv
// rendering_mul_pipe: pipelined integer multiplier with per-operand signedness, valid tracking and overflow flag.
// Optional: define RENDERING_MUL_SAT_EN to clamp overflowing results instead of wrapping.
module rendering_mul_pipe #(
   parameter int ID          = 1,
   parameter int NUM_STAGE   = 3,
   parameter int din0_WIDTH  = 8,
   parameter int din1_WIDTH  = 10,
   parameter int dout_WIDTH  = 17,
   parameter int din0_SIGNED = 0,
   parameter int din1_SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  din_vld,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  dout_vld,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  ovf,
   output logic                  busy
);
   localparam int unsigned PW     = din0_WIDTH + din1_WIDTH + 2;
   localparam int unsigned DW     = dout_WIDTH;
   localparam int unsigned XW     = ((PW > DW) ? PW : DW) + 1;
   localparam int unsigned RDEPTH = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
   localparam bit          RS     = (din0_SIGNED != 0) || (din1_SIGNED != 0);
   // Representable dout range, held one bit wider than needed so both bounds stay exact
   localparam logic signed [XW-1:0] RMAX = RS ? (XW'(1) << (DW - 1)) - XW'(1)
                                              : (XW'(1) << DW) - XW'(1);
   localparam logic signed [XW-1:0] RMIN = RS ? -(XW'(1) << (DW - 1)) : '0;

   logic [din0_WIDTH:0] ext0;
   logic [din1_WIDTH:0] ext1;
   logic                unused_id;

   assign ext0      = {(din0_SIGNED != 0) && din0[din0_WIDTH-1], din0};
   assign ext1      = {(din1_SIGNED != 0) && din1[din1_WIDTH-1], din1};
   assign unused_id = (ID != 0);

   // Exact signed product, sign-extended so range checks never truncate
   function automatic logic signed [XW-1:0] full_product(input logic [din0_WIDTH:0] a,
                                                         input logic [din1_WIDTH:0] b);
      logic signed [PW-1:0] p;
      p = PW'(signed'(a)) * PW'(signed'(b));
      return XW'(p);
   endfunction

   function automatic logic out_of_range(input logic signed [XW-1:0] p);
      return (p > RMAX) || (p < RMIN);
   endfunction

   function automatic logic [dout_WIDTH-1:0] map_result(input logic signed [XW-1:0] p);
`ifdef RENDERING_MUL_SAT_EN
      if (p > RMAX) return RMAX[dout_WIDTH-1:0];
      if (p < RMIN) return RMIN[dout_WIDTH-1:0];
`endif
      return p[dout_WIDTH-1:0];
   endfunction

   generate
      if (NUM_STAGE == 0) begin : g_comb
         logic signed [XW-1:0] p;
         logic                 unused_seq;

         assign p          = full_product(ext0, ext1);
         assign dout_vld   = din_vld && !reset;
         assign dout       = reset ? '0 : map_result(p);
         assign ovf        = din_vld && !reset && out_of_range(p);
         assign busy       = 1'b0;
         assign unused_seq = clk ^ ce;
      end else if (NUM_STAGE == 1) begin : g_one
         logic signed [XW-1:0]  p;
         logic                  q_vld;
         logic                  q_ovf;
         logic [dout_WIDTH-1:0] q_dat;

         assign p = full_product(ext0, ext1);

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               q_vld <= 1'b0;
               q_ovf <= 1'b0;
               q_dat <= '0;
            end else if (ce) begin
               q_vld <= din_vld;
               q_ovf <= din_vld && out_of_range(p);
               q_dat <= map_result(p);
            end
         end

         assign dout_vld = q_vld;
         assign dout     = q_dat;
         assign ovf      = q_ovf;
         assign busy     = q_vld;
      end else begin : g_pipe
         logic                  s1_vld;
         logic [din0_WIDTH:0]   s1_a;
         logic [din1_WIDTH:0]   s1_b;
         logic signed [XW-1:0]  s1_p;
         logic [RDEPTH-1:0]     r_vld;
         logic [RDEPTH-1:0]     r_ovf;
         logic [dout_WIDTH-1:0] r_dat [RDEPTH];

         assign s1_p = full_product(s1_a, s1_b);

         // Operand stage followed by a result shift chain; ce=0 freezes everything
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               s1_vld <= 1'b0;
               s1_a   <= '0;
               s1_b   <= '0;
               r_vld  <= '0;
               r_ovf  <= '0;
               for (int i = 0; i < int'(RDEPTH); i++) r_dat[i] <= '0;
            end else if (ce) begin
               s1_vld   <= din_vld;
               s1_a     <= ext0;
               s1_b     <= ext1;
               r_vld[0] <= s1_vld;
               r_ovf[0] <= s1_vld && out_of_range(s1_p);
               r_dat[0] <= map_result(s1_p);
               for (int i = 1; i < int'(RDEPTH); i++) begin
                  r_vld[i] <= r_vld[i-1];
                  r_ovf[i] <= r_ovf[i-1];
                  r_dat[i] <= r_dat[i-1];
               end
            end
         end

         assign dout_vld = r_vld[RDEPTH-1];
         assign dout     = r_dat[RDEPTH-1];
         assign ovf      = r_ovf[RDEPTH-1];
         assign busy     = s1_vld || (|r_vld);
      end
   endgenerate
endmodule

// File: tb/tb_rendering_mul_pipe.sv
// Bench for rendering_mul_pipe: default, signed-din0 and combinational instances share one stimulus bus.
module tb_rendering_mul_pipe;
   localparam int unsigned DW = 17;

   logic          clk = 1'b0;
   logic          reset;
   logic          ce;
   logic          din_vld;
   logic [7:0]    din0;
   logic [9:0]    din1;
   logic [DW-1:0] u_dout, s_dout, c_dout;
   logic          u_vld, u_ovf, u_busy;
   logic          s_vld, s_ovf, s_busy;
   logic          c_vld, c_ovf, c_busy;
   int            vectors = 0;
   int            miscompares = 0;

   typedef struct {
      int            due;
      logic [DW-1:0] ud;
      logic          uo;
      logic [DW-1:0] sd;
      logic          so;
   } item_t;
   item_t sb[$];
   int    cnt;

   always #5 clk = ~clk;

   rendering_mul_pipe #(.ID(1)) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
      .dout_vld(u_vld), .dout(u_dout), .ovf(u_ovf), .busy(u_busy));

   rendering_mul_pipe #(.ID(2), .din0_SIGNED(1)) u_sgn (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
      .dout_vld(s_vld), .dout(s_dout), .ovf(s_ovf), .busy(s_busy));

   rendering_mul_pipe #(.ID(3), .NUM_STAGE(0)) u_comb (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
      .dout_vld(c_vld), .dout(c_dout), .ovf(c_ovf), .busy(c_busy));

   // Reference: exact integer product, then range check and wrap/clamp into 17 bits
   function automatic void ref_mul(input logic [7:0] a, input logic [9:0] b, input bit s0,
                                   output logic [DW-1:0] d, output logic o);
      longint      va, vb, p, lo, hi;
      logic [63:0] pu;
      va = s0 ? longint'($signed(a)) : longint'(a);
      vb = longint'(b);
      p  = va * vb;
      lo = s0 ? -(longint'(1) << 16) : 0;
      hi = s0 ? (longint'(1) << 16) - 1 : (longint'(1) << 17) - 1;
      o  = (p < lo) || (p > hi);
      pu = p;
      d  = pu[DW-1:0];
`ifdef RENDERING_MUL_SAT_EN
      if (o) d = s0 ? ((p < 0) ? 17'h10000 : 17'h0FFFF) : 17'h1FFFF;
`endif
   endfunction

   task automatic test_reset();
      reset = 1'b1; ce = 1'b1; din_vld = 1'b1; din0 = 8'd200; din1 = 10'd500;
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if ({u_vld, u_ovf, u_busy, u_dout} !== 20'd0) begin
         miscompares++;
         $display("FAIL reset_dut: got vld=%b ovf=%b busy=%b dout=%0d, want all 0", u_vld, u_ovf, u_busy, u_dout);
      end
      vectors++;
      if ({s_vld, s_ovf, s_busy, s_dout} !== 20'd0) begin
         miscompares++;
         $display("FAIL reset_sgn: got vld=%b ovf=%b busy=%b dout=%0d, want all 0", s_vld, s_ovf, s_busy, s_dout);
      end
      vectors++;
      if ({c_vld, c_ovf, c_busy, c_dout} !== 20'd0) begin
         miscompares++;
         $display("FAIL reset_comb: got vld=%b ovf=%b busy=%b dout=%0d, want all 0", c_vld, c_ovf, c_busy, c_dout);
      end
      reset = 1'b0; din_vld = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (u_vld !== 1'b0 || u_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: got vld=%b busy=%b, want 0 0", u_vld, u_busy);
      end
   endtask

   task automatic test_directed();
      bit            sel [4];
      logic [7:0]    a   [4];
      logic [9:0]    b   [4];
      logic [DW-1:0] ed  [4];
      logic          eo  [4];
      logic [DW-1:0] od;
      logic          ov, oo, ob;
      sel[0] = 0; a[0] = 8'd200; b[0] = 10'd500;  ed[0] = 17'd100000; eo[0] = 1'b0;
      sel[1] = 0; a[1] = 8'd255; b[1] = 10'd1023; eo[1] = 1'b1;
      sel[2] = 1; a[2] = 8'hFF;  b[2] = 10'd10;   ed[2] = 17'h1FFF6;  eo[2] = 1'b0;
      sel[3] = 1; a[3] = 8'h80;  b[3] = 10'd1023; eo[3] = 1'b1;
`ifdef RENDERING_MUL_SAT_EN
      ed[1] = 17'd131071; ed[3] = 17'h10000;
`else
      ed[1] = 17'd129793; ed[3] = 17'h00080;
`endif
      for (int v = 0; v < 4; v++) begin
         ce = 1'b1; din_vld = 1'b1; din0 = a[v]; din1 = b[v];
         for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) din_vld = 1'b0;
            od = sel[v] ? s_dout : u_dout;
            ov = sel[v] ? s_vld  : u_vld;
            oo = sel[v] ? s_ovf  : u_ovf;
            ob = sel[v] ? s_busy : u_busy;
            vectors++;
            if (ov !== (k == 3) || ob !== (k <= 3) || oo !== ((k == 3) ? eo[v] : 1'b0)) begin
               miscompares++;
               $display("FAIL directed_timing v%0d cycle %0d: got vld=%b busy=%b ovf=%b, want vld=%b busy=%b ovf=%b",
                        v, k, ov, ob, oo, (k == 3), (k <= 3), (k == 3) ? eo[v] : 1'b0);
            end
            if (k == 3) begin
               vectors++;
               if (od !== ed[v]) begin
                  miscompares++;
                  $display("FAIL directed_dout v%0d: got %h, want %h", v, od, ed[v]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit            ce_tab [10];
      bit            vld_exp;
      logic [DW-1:0] d_exp;
      int            k;
      int            outk;
      for (int s = 0; s < 10; s++) ce_tab[s] = !(s == 2 || s == 3);
      k = 1;
      for (int s = 0; s < 10; s++) begin
         ce = ce_tab[s]; din_vld = (k <= 5);
         din0 = 8'(k * 3); din1 = 10'(k * 7);
         @(posedge clk);
         if (ce && din_vld) k++;
         #1;
         vld_exp = (s >= 4 && s <= 8);
         outk    = s - 3;
         d_exp   = DW'(21 * outk * outk);
         vectors++;
         if (u_vld !== vld_exp || u_busy !== (s <= 8) || u_ovf !== 1'b0 || (vld_exp && u_dout !== d_exp)) begin
            miscompares++;
            $display("FAIL back_to_back step %0d: got vld=%b busy=%b ovf=%b dout=%0d, want vld=%b busy=%b ovf=0 dout=%0d",
                     s, u_vld, u_busy, u_ovf, u_dout, vld_exp, (s <= 8), d_exp);
         end
      end
      din_vld = 1'b0; ce = 1'b1;
   endtask

   task automatic test_reset_midflight();
      logic [DW-1:0] ed, dummy_d;
      logic          eo, dummy_o;
      ce = 1'b1; din_vld = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         din0 = 8'($urandom); din1 = 10'($urandom);
         @(posedge clk); #1;
      end
      vectors++;
      if (u_vld !== 1'b1 || u_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midflight_fill: got vld=%b busy=%b, want 1 1", u_vld, u_busy);
      end
      #2; reset = 1'b1; #1;
      for (int r = 0; r < 2; r++) begin
         vectors++;
         if ({u_vld, u_ovf, u_busy, u_dout, s_vld, s_ovf, s_busy, s_dout} !== 40'd0) begin
            miscompares++;
            $display("FAIL midflight_reset %0d: got dut vld=%b busy=%b ovf=%b dout=%0d sgn vld=%b busy=%b ovf=%b dout=%0d, want all 0",
                     r, u_vld, u_busy, u_ovf, u_dout, s_vld, s_busy, s_ovf, s_dout);
         end
         if (r == 0) begin @(posedge clk); #1; end
      end
      reset = 1'b0; din_vld = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (u_vld !== 1'b0 || u_busy !== 1'b0 || s_vld !== 1'b0 || s_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_late cycle %0d: got vld=%b/%b busy=%b/%b, want 0", k, u_vld, s_vld, u_busy, s_busy);
         end
      end
      din0 = 8'($urandom); din1 = 10'($urandom); din_vld = 1'b1;
      ref_mul(din0, din1, 1'b0, ed, eo);
      ref_mul(din0, din1, 1'b1, dummy_d, dummy_o);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (k == 1) din_vld = 1'b0;
         vectors++;
         if (u_vld !== (k == 3) || (k == 3 && (u_dout !== ed || u_ovf !== eo)) || s_vld !== (k == 3)
             || (k == 3 && (s_dout !== dummy_d || s_ovf !== dummy_o))) begin
            miscompares++;
            $display("FAIL midflight_restart cycle %0d: got vld=%b dout=%h ovf=%b, want vld=%b dout=%h ovf=%b",
                     k, u_vld, u_dout, u_ovf, (k == 3), ed, eo);
         end
      end
   endtask

   task automatic test_random();
      item_t         it;
      bit            ev, eb;
      logic [DW-1:0] eud, esd;
      logic          euo, eso;
      cnt = 0; sb.delete();
      for (int n = 0; n < 406; n++) begin
         if (n < 400) begin
            ce      = ($urandom_range(0, 3) != 0);
            din_vld = ($urandom_range(0, 4) < 3);
            din0    = 8'($urandom);
            din1    = 10'($urandom);
            if ($urandom_range(0, 7) == 0) din0 = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h80;
            if ($urandom_range(0, 7) == 0) din1 = 10'h3FF;
         end else begin
            ce = 1'b1; din_vld = 1'b0;
         end
         @(posedge clk);
         if (ce) begin
            cnt++;
            if (din_vld) begin
               it.due = cnt + 2;
               ref_mul(din0, din1, 1'b0, it.ud, it.uo);
               ref_mul(din0, din1, 1'b1, it.sd, it.so);
               sb.push_back(it);
            end
            while (sb.size() > 0 && sb[0].due < cnt) sb.delete(0);
         end
         #1;
         eb = (sb.size() > 0);
         ev = eb && (sb[0].due == cnt);
         eud = ev ? sb[0].ud : '0; euo = ev ? sb[0].uo : 1'b0;
         esd = ev ? sb[0].sd : '0; eso = ev ? sb[0].so : 1'b0;
         vectors++;
         if (u_vld !== ev || u_busy !== eb || u_ovf !== euo || (ev && u_dout !== eud)) begin
            miscompares++;
            $display("FAIL random_dut n=%0d: got vld=%b busy=%b ovf=%b dout=%h, want vld=%b busy=%b ovf=%b dout=%h",
                     n, u_vld, u_busy, u_ovf, u_dout, ev, eb, euo, eud);
         end
         vectors++;
         if (s_vld !== ev || s_busy !== eb || s_ovf !== eso || (ev && s_dout !== esd)) begin
            miscompares++;
            $display("FAIL random_sgn n=%0d: got vld=%b busy=%b ovf=%b dout=%h, want vld=%b busy=%b ovf=%b dout=%h",
                     n, s_vld, s_busy, s_ovf, s_dout, ev, eb, eso, esd);
         end
      end
   endtask

   task automatic test_comb();
      logic [DW-1:0] ed;
      logic          eo;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         ce      = ($urandom_range(0, 1) != 0);
         din_vld = ($urandom_range(0, 3) != 0);
         din0    = (n == 0) ? 8'hFF : 8'($urandom);
         din1    = (n == 0) ? 10'h3FF : 10'($urandom);
         ref_mul(din0, din1, 1'b0, ed, eo);
         #2;
         vectors++;
         if (c_vld !== din_vld || c_busy !== 1'b0 || c_ovf !== (din_vld && eo) || (din_vld && c_dout !== ed)) begin
            miscompares++;
            $display("FAIL comb n=%0d a=%0d b=%0d: got vld=%b busy=%b ovf=%b dout=%0d, want vld=%b busy=0 ovf=%b dout=%0d",
                     n, din0, din1, c_vld, c_busy, c_ovf, c_dout, din_vld, din_vld && eo, ed);
         end
      end
      din_vld = 1'b0; ce = 1'b1;
   endtask

   initial begin
      reset = 1'b1; ce = 1'b0; din_vld = 1'b0; din0 = '0; din1 = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      test_comb();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
